// File: rtl/if_id_stage.sv
// ---------------------------------------------------------------------------
// if_id_stage
//   Pipeline stage between instruction fetch and decode. Holds up to two
//   {pc, instr} entries: a main register that drives decode and a skid
//   register that absorbs the one entry fetch may push in the cycle decode
//   stalls. up_ready and dn_valid are decoded from the registered state only,
//   so there is no combinational path from dn_ready to up_ready. A
//   synchronous flush empties the stage on a branch/jump redirect.
//
// Ports
//   clk       in   1   rising-edge clock
//   rst_n     in   1   asynchronous active-low reset
//   flush     in   1   synchronous flush; next state is empty
//   up_valid  in   1   fetch presents {up_pc, up_instr}
//   up_ready  out  1   stage accepts an entry this cycle
//   up_pc     in   AW  pc of fetched instruction
//   up_instr  in   DW  fetched instruction word
//   dn_valid  out  1   decode sees a valid {dn_pc, dn_instr}
//   dn_ready  in   1   decode accepts the entry this cycle
//   dn_pc     out  AW  pc to decode
//   dn_instr  out  DW  instruction to decode; NOP while dn_valid=0
//   occ       out  2   number of held entries (0, 1 or 2)
// ---------------------------------------------------------------------------
module if_id_stage #(
  parameter int unsigned    DW  = 32,
  parameter int unsigned    AW  = 32,
  parameter logic [DW-1:0]  NOP = 32'h00000013
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          up_valid,
  output logic          up_ready,
  input  logic [AW-1:0] up_pc,
  input  logic [DW-1:0] up_instr,
  output logic          dn_valid,
  input  logic          dn_ready,
  output logic [AW-1:0] dn_pc,
  output logic [DW-1:0] dn_instr,
  output logic [1:0]    occ
);

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HALF  = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] m_pc_q, m_pc_d;
  logic [DW-1:0] m_instr_q, m_instr_d;
  logic [AW-1:0] s_pc_q, s_pc_d;
  logic [DW-1:0] s_instr_q, s_instr_d;

  logic up_ready_s;
  logic dn_valid_s;
  logic up_fire_s;
  logic dn_fire_s;

  // Handshake flags depend on registered state only.
  assign up_ready_s = (state_q != ST_FULL);
  assign dn_valid_s = (state_q != ST_EMPTY);
  assign up_fire_s  = up_valid & up_ready_s;
  assign dn_fire_s  = dn_valid_s & dn_ready;

  assign up_ready = up_ready_s;
  assign dn_valid = dn_valid_s;
  assign occ      = state_q;
  assign dn_pc    = m_pc_q;
  // Stale main data after a flush is masked here rather than cleared.
  assign dn_instr = dn_valid_s ? m_instr_q : NOP;

  // Next-state and data-path selection; flush overrides every transfer.
  always_comb begin
    state_d   = state_q;
    m_pc_d    = m_pc_q;
    m_instr_d = m_instr_q;
    s_pc_d    = s_pc_q;
    s_instr_d = s_instr_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (up_fire_s) begin
            m_pc_d    = up_pc;
            m_instr_d = up_instr;
            state_d   = ST_HALF;
          end else begin
            state_d = ST_EMPTY;
          end
        end
        ST_HALF: begin
          if (up_fire_s && dn_fire_s) begin
            m_pc_d    = up_pc;
            m_instr_d = up_instr;
            state_d   = ST_HALF;
          end else if (up_fire_s) begin
            // Decode stalled: park the new entry behind the main one.
            s_pc_d    = up_pc;
            s_instr_d = up_instr;
            state_d   = ST_FULL;
          end else if (dn_fire_s) begin
            state_d = ST_EMPTY;
          end else begin
            state_d = ST_HALF;
          end
        end
        ST_FULL: begin
          if (dn_fire_s) begin
            m_pc_d    = s_pc_q;
            m_instr_d = s_instr_q;
            state_d   = ST_HALF;
          end else begin
            state_d = ST_FULL;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
  end

  // State and data registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_EMPTY;
      m_pc_q    <= {AW{1'b0}};
      m_instr_q <= {DW{1'b0}};
      s_pc_q    <= {AW{1'b0}};
      s_instr_q <= {DW{1'b0}};
    end else begin
      state_q   <= state_d;
      m_pc_q    <= m_pc_d;
      m_instr_q <= m_instr_d;
      s_pc_q    <= s_pc_d;
      s_instr_q <= s_instr_d;
    end
  end

endmodule

// File: tb/tb_if_id_stage.sv
module tb_if_id_stage;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        up_valid;
  logic        up_ready;
  logic [31:0] up_pc;
  logic [31:0] up_instr;
  logic        dn_valid;
  logic        dn_ready;
  logic [31:0] dn_pc;
  logic [31:0] dn_instr;
  logic [1:0]  occ;

  if_id_stage dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .up_valid (up_valid),
    .up_ready (up_ready),
    .up_pc    (up_pc),
    .up_instr (up_instr),
    .dn_valid (dn_valid),
    .dn_ready (dn_ready),
    .dn_pc    (dn_pc),
    .dn_instr (dn_instr),
    .occ      (occ)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  bit   chk_en  = 1'b0;

  // Reference model: the stage is a FIFO of at most two entries.
  ent_t mq[$];
  bit   stall_prev = 1'b0;
  ent_t prev_front;
  int   delivered = 0;
  bit   have_del  = 1'b0;
  logic [31:0] last_pc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update at each edge from the inputs presented before it.
  initial begin
    ent_t e;
    int   sz;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mq.delete();
        stall_prev = 1'b0;
      end else begin
        sz = mq.size();
        stall_prev = (sz > 0) && !dn_ready && !flush;
        if (sz > 0) prev_front = mq[0];
        if (sz > 0 && dn_ready) begin
          e = mq.pop_front();
          if (have_del) chk("order", 32'(e.pc > last_pc), 32'd1);
          last_pc  = e.pc;
          have_del = 1'b1;
          delivered++;
        end
        if (up_valid && sz < 2 && !flush) mq.push_back({up_pc, up_instr});
        if (flush) mq.delete();
      end
    end
  end

  // Compare process: DUT outputs against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("occ", 32'(occ), 32'(mq.size()));
      chk("dn_valid", 32'(dn_valid), 32'(mq.size() > 0));
      chk("up_ready", 32'(up_ready), 32'(mq.size() < 2));
      if (mq.size() > 0) begin
        chk("dn_pc", dn_pc, mq[0].pc);
        chk("dn_instr", dn_instr, mq[0].instr);
      end else begin
        chk("dn_instr_nop", dn_instr, NOP);
      end
      if (stall_prev) begin
        chk("stable_pc", dn_pc, prev_front.pc);
        chk("stable_instr", dn_instr, prev_front.instr);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] next_pc;
  int          start_del;
  int          cyc;

  initial begin
    rst_n = 1'b0; flush = 1'b0; up_valid = 1'b0; dn_ready = 1'b0;
    up_pc = 32'h0; up_instr = 32'h0;
    #2 chk_en = 1'b1;
    // 1 Reset values
    #10;
    chk("rst_dn_valid", 32'(dn_valid), 32'd0);
    chk("rst_up_ready", 32'(up_ready), 32'd1);
    chk("rst_occ", 32'(occ), 32'd0);
    chk("rst_dn_pc", dn_pc, 32'h0);
    chk("rst_dn_instr", dn_instr, 32'h00000013);
    rst_n = 1'b1;
    tick();

    // 2 Streaming, no bubbles
    up_valid = 1'b1; dn_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      up_pc = 32'(4 * i); up_instr = 32'h1000_0000 + 32'(i);
      tick();
      chk("stream_pc", dn_pc, 32'(4 * i));
      chk("stream_instr", dn_instr, 32'h1000_0000 + 32'(i));
      chk("stream_valid", 32'(dn_valid), 32'd1);
      chk("stream_occ", 32'(occ), 32'd1);
    end
    up_valid = 1'b0;
    tick();
    chk("stream_drain", 32'(occ), 32'd0);

    // 3 Backpressure into the skid entry
    dn_ready = 1'b0; up_valid = 1'b1; up_pc = 32'h100; up_instr = 32'hA100;
    tick();
    up_pc = 32'h104; up_instr = 32'hA104;
    tick();
    chk("bp_occ2", 32'(occ), 32'd2);
    chk("bp_up_ready", 32'(up_ready), 32'd0);
    chk("bp_hold_pc", dn_pc, 32'h100);
    up_valid = 1'b0; dn_ready = 1'b1;
    tick();
    chk("bp_second_pc", dn_pc, 32'h104);
    tick();
    chk("bp_empty", 32'(occ), 32'd0);

    // 4 Flush while full, with a push offered in the same cycle
    dn_ready = 1'b0; up_valid = 1'b1; up_pc = 32'h180; up_instr = 32'hA180;
    tick();
    up_pc = 32'h184; up_instr = 32'hA184;
    tick();
    up_pc = 32'h200; up_instr = 32'hA200; flush = 1'b1;
    tick();
    chk("fl_occ", 32'(occ), 32'd0);
    chk("fl_valid", 32'(dn_valid), 32'd0);
    chk("fl_nop", dn_instr, NOP);
    flush = 1'b0; up_valid = 1'b0;
    tick();
    chk("fl_stay_empty", 32'(occ), 32'd0);

    // 5 Asynchronous reset while full
    up_valid = 1'b1; up_pc = 32'h300; up_instr = 32'hA300;
    tick();
    up_pc = 32'h304; up_instr = 32'hA304;
    tick();
    up_valid = 1'b0;
    chk("ar_full", 32'(occ), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", 32'(dn_valid), 32'd0);
    chk("ar_occ", 32'(occ), 32'd0);
    chk("ar_up_ready", 32'(up_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    up_valid = 1'b1; up_pc = 32'h308; up_instr = 32'hA308;
    tick();
    chk("ar_first_pc", dn_pc, 32'h308);
    chk("ar_first_instr", dn_instr, 32'hA308);
    up_valid = 1'b0; dn_ready = 1'b1;
    tick();

    // 6 Random traffic against the model
    next_pc   = 32'h1000;
    start_del = delivered;
    cyc       = 0;
    while ((delivered - start_del) < 1000 && cyc < 20000) begin
      up_valid = ($urandom_range(0, 3) != 0);
      dn_ready = ($urandom_range(0, 3) != 0);
      flush    = ($urandom_range(0, 31) == 0);
      up_pc    = next_pc;
      up_instr = $urandom;
      next_pc  = next_pc + 32'd4;
      tick();
      cyc++;
    end
    chk("rand_done", 32'((delivered - start_del) >= 1000), 32'd1);
    up_valid = 1'b0; flush = 1'b0; dn_ready = 1'b1;
    tick();
    tick();
    chk("final_empty", 32'(occ), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
